// File: rtl/thread_fetch_scheduler_pkg.sv
// Shared types and configuration for the multi-threaded fetch scheduler.
package thread_pkg;

  // Core configuration record; the scheduler takes its thread count from here.
  typedef struct packed {
    int unsigned NUM_THREADS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg = '{NUM_THREADS: 32'd2};

  // Thread-ID width; a single thread still needs one bit of ID.
  function automatic int unsigned calc_tid_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CFG_TID_W = calc_tid_w(cva6_cfg.NUM_THREADS);

  typedef logic [CFG_TID_W-1:0] tid_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SWITCH
  } state_t;

endpackage

// File: rtl/thread_fetch_scheduler_if.sv
// Fetch-slot bus between the thread scheduler and the fetch frontend.
interface thread_fetch_scheduler_if
  import thread_pkg::*;
#(
  parameter int unsigned NUM_THREADS = cva6_cfg.NUM_THREADS
);
  localparam int unsigned TID_W = calc_tid_w(NUM_THREADS);

  logic [NUM_THREADS-1:0] thread_active_i;
  logic [NUM_THREADS-1:0] thread_stall_i;
  logic                   fetch_ready_i;
  logic                   fetch_valid_o;
  logic [TID_W-1:0]       fetch_tid_o;
  logic                   switch_o;

  modport master (
    input  thread_active_i,
    input  thread_stall_i,
    input  fetch_ready_i,
    output fetch_valid_o,
    output fetch_tid_o,
    output switch_o
  );

  modport slave (
    output thread_active_i,
    output thread_stall_i,
    output fetch_ready_i,
    input  fetch_valid_o,
    input  fetch_tid_o,
    input  switch_o
  );

endinterface

// File: rtl/thread_fetch_scheduler_rr_pick.sv
// Combinational round-robin search: first eligible thread at or after start,
// wrapping, optionally skipping one thread (the one currently running).
module thread_rr_pick #(
  parameter int unsigned NUM_THREADS = 2,
  parameter int unsigned TID_W       = 1
) (
  input  logic [NUM_THREADS-1:0] eligible,
  input  logic [TID_W-1:0]       start,
  input  logic                   excl_en,
  input  logic [TID_W-1:0]       excl_tid,
  output logic                   found,
  output logic [TID_W-1:0]       tid
);

  localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);

  logic [NUM_THREADS-1:0] cand;
  logic [NUM_THREADS-1:0] rot;
  logic [TID_W-1:0]       idx;

  // Rotate candidates so bit 0 is the start thread, then take the first set bit.
  always_comb begin
    cand  = eligible & ~(excl_en ? (NUM_THREADS'(1) << excl_tid) : '0);
    rot   = NUM_THREADS'({cand, cand} >> start);
    idx   = start;
    found = 1'b0;
    tid   = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      if (!found && rot[0]) begin
        found = 1'b1;
        tid   = idx;
      end
      rot = rot >> 1;
      idx = (idx == LAST_TID) ? '0 : idx + TID_W'(1);
    end
  end

endmodule

// File: rtl/thread_fetch_scheduler.sv
// Time-slices the fetch frontend between hardware threads: a thread keeps the
// slot for QUANTUM accepted fetches, then yields round-robin via a one-cycle
// bubble. Stalled or disabled threads give up the slot immediately.
module thread_fetch_scheduler
  import thread_pkg::*;
#(
  parameter int unsigned NUM_THREADS = cva6_cfg.NUM_THREADS,
  parameter int unsigned QUANTUM     = 4
) (
  input logic                       clk_i,
  input logic                       rst_i,
  thread_fetch_scheduler_if.master  bus
);

  localparam int unsigned      TID_W    = calc_tid_w(NUM_THREADS);
  localparam logic [TID_W-1:0] LAST_TID = TID_W'(NUM_THREADS - 1);
  localparam logic [7:0]       Q_LAST   = 8'(QUANTUM - 1);

  state_t                 state, state_n;
  logic [TID_W-1:0]       cur_tid, cur_tid_n;
  logic [TID_W-1:0]       rr_ptr, rr_ptr_n;
  logic [7:0]             cnt, cnt_n;
  logic                   switch_q;

  logic [NUM_THREADS-1:0] elig;
  logic                   cur_elig;
  logic                   pick_excl;
  logic                   pick_found;
  logic [TID_W-1:0]       pick_tid;
  logic                   fetch_valid;
  logic                   handshake;

  function automatic logic [TID_W-1:0] ptr_after(input logic [TID_W-1:0] t);
    return (t == LAST_TID) ? '0 : t + TID_W'(1);
  endfunction

  assign elig      = bus.thread_active_i & ~bus.thread_stall_i;
  assign cur_elig  = |(elig & (NUM_THREADS'(1) << cur_tid));
  assign pick_excl = (state == RUN);

  thread_rr_pick #(
    .NUM_THREADS (NUM_THREADS),
    .TID_W       (TID_W)
  ) u_pick (
    .eligible (elig),
    .start    (rr_ptr),
    .excl_en  (pick_excl),
    .excl_tid (cur_tid),
    .found    (pick_found),
    .tid      (pick_tid)
  );

  // Scheduler state; reset aborts any run or switch in progress.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cur_tid  <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      switch_q <= 1'b0;
    end else begin
      state    <= state_n;
      cur_tid  <= cur_tid_n;
      rr_ptr   <= rr_ptr_n;
      cnt      <= cnt_n;
      switch_q <= (cur_tid_n != cur_tid);
    end
  end

  // Next-state, thread selection and quantum accounting.
  always_comb begin
    state_n     = state;
    cur_tid_n   = cur_tid;
    rr_ptr_n    = rr_ptr;
    cnt_n       = cnt;
    fetch_valid = 1'b0;
    handshake   = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          cur_tid_n = pick_tid;
          rr_ptr_n  = ptr_after(pick_tid);
          cnt_n     = '0;
          state_n   = RUN;
        end
      end
      RUN: begin
        fetch_valid = cur_elig;
        handshake   = cur_elig && bus.fetch_ready_i;
        if (!cur_elig) begin
          // Losing eligibility outranks quantum expiry.
          if (pick_found) begin
            cur_tid_n = pick_tid;
            rr_ptr_n  = ptr_after(pick_tid);
            cnt_n     = '0;
            state_n   = SWITCH;
          end else begin
            state_n = IDLE;
          end
        end else if (handshake) begin
          if (cnt == Q_LAST) begin
            cnt_n = '0;
            if (pick_found) begin
              cur_tid_n = pick_tid;
              rr_ptr_n  = ptr_after(pick_tid);
              state_n   = SWITCH;
            end
          end else begin
            cnt_n = cnt + 8'd1;
          end
        end
      end
      SWITCH: begin
        cnt_n   = '0;
        state_n = RUN;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.fetch_valid_o = fetch_valid;
  assign bus.fetch_tid_o   = cur_tid;
  assign bus.switch_o      = switch_q;

endmodule
